// File: rtl/bp_fe_bp_update_sched_pkg.sv
// Shared types for the branch-predictor update scheduler.
// Holds the drain FSM encoding and the queue entry width helper.
package bp_fe_bp_sched_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } bp_sched_state_e;

    // Queue entry is {idx, correct}.
    function automatic int entry_width(input int idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/bp_fe_bp_update_sched_if.sv
// Update channels and predictor write port of the update scheduler.
// master = requesters/predictor side, slave = scheduler.
interface bp_fe_bp_update_sched_if #(
    parameter int bht_idx_width_p = 10
);

    logic                       cmt_v_i;
    logic [bht_idx_width_p-1:0] cmt_idx_i;
    logic                       cmt_correct_i;
    logic                       cmt_ready_o;

    logic                       rdr_v_i;
    logic [bht_idx_width_p-1:0] rdr_idx_i;
    logic                       rdr_correct_i;
    logic                       rdr_ready_o;

    logic                       w_v_o;
    logic [bht_idx_width_p-1:0] idx_w_o;
    logic                       correct_o;

    modport master (
        output cmt_v_i, cmt_idx_i, cmt_correct_i,
        input  cmt_ready_o,
        output rdr_v_i, rdr_idx_i, rdr_correct_i,
        input  rdr_ready_o,
        input  w_v_o, idx_w_o, correct_o
    );

    modport slave (
        input  cmt_v_i, cmt_idx_i, cmt_correct_i,
        output cmt_ready_o,
        input  rdr_v_i, rdr_idx_i, rdr_correct_i,
        output rdr_ready_o,
        output w_v_o, idx_w_o, correct_o
    );

endinterface

// File: rtl/bp_fe_bp_update_fifo.sv
// Circular update queue; pointers carry an extra wrap bit
// so full and empty are told apart by the MSB.
module bp_fe_bp_update_fifo #(
    parameter int width_p = 11,
    parameter int els_p   = 4,
    localparam int aw     = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o,
    output logic [aw:0]        count_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [width_p-1:0] mem [els_p];
    logic [aw:0]        wptr_q;
    logic [aw:0]        rptr_q;
    logic               enq;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[aw] != rptr_q[aw])
                   && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign ready_o = ~full_o;
    assign enq     = v_i & ~full_o;
    assign data_o  = mem[rptr_q[aw-1:0]];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (enq)
                wptr_q <= wptr_q + 1'b1;
            if (yumi_i)
                rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wptr_q[aw-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_fe_bp_update_sched.sv
// Merges commit and redirect predictor updates into one ordered
// write stream, with hold and a drain handshake for quiescing.
module bp_fe_bp_update_sched
    import bp_fe_bp_sched_pkg::*;
#(
    parameter int bht_idx_width_p = 10,
    parameter int fifo_els_p      = 4,
    localparam int cw = $clog2(fifo_els_p) + 1,
    localparam int ew = entry_width(bht_idx_width_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    bp_fe_bp_update_sched_if.slave     upd,
    input  logic                       hold_i,
    input  logic                       drain_i,
    output logic                       drained_o,
    output logic [cw-1:0]              count_o
);

    bp_sched_state_e state_q;
    logic            rr_q;
    logic            drained_q;

    logic            full;
    logic            empty;
    logic            run;
    logic            cmt_go;
    logic            rdr_go;
    logic            enq_v;
    logic            contested;
    logic            w_v;
    logic [ew-1:0]   enq_data;
    logic [ew-1:0]   head;

    assign run = (state_q == RUN) & reset_n_i;

    // rr_q=0 favours commit, rr_q=1 favours redirect
    assign upd.cmt_ready_o = ~full & run
                           & (~upd.rdr_v_i | ~rr_q);
    assign upd.rdr_ready_o = ~full & run
                           & (~upd.cmt_v_i | rr_q);

    assign cmt_go    = upd.cmt_v_i & upd.cmt_ready_o;
    assign rdr_go    = upd.rdr_v_i & upd.rdr_ready_o;
    assign enq_v     = cmt_go | rdr_go;
    assign contested = upd.cmt_v_i & upd.rdr_v_i & enq_v;
    assign enq_data  = cmt_go
                     ? {upd.cmt_idx_i, upd.cmt_correct_i}
                     : {upd.rdr_idx_i, upd.rdr_correct_i};

    assign w_v           = ~empty & ~hold_i & reset_n_i;
    assign upd.w_v_o     = w_v;
    assign upd.idx_w_o   = w_v ? head[ew-1:1] : '0;
    assign upd.correct_o = w_v & head[0];
    assign drained_o     = drained_q;

    bp_fe_bp_update_fifo #(
        .width_p (ew),
        .els_p   (fifo_els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (enq_v),
        .data_i    (enq_data),
        .ready_o   (),
        .yumi_i    (w_v),
        .data_o    (head),
        .count_o   (count_o),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= RUN;
            rr_q      <= 1'b0;
            drained_q <= 1'b0;
        end else begin
            drained_q <= 1'b0;
            if (contested)
                rr_q <= ~rr_q;
            unique case (state_q)
                RUN: begin
                    if (drain_i)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (count_o == '0) begin
                        state_q   <= DONE;
                        drained_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_update_sched.sv
// Directed-vector bench for the predictor update scheduler.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_bp_fe_bp_update_sched;

    localparam int IW = 4;
    localparam int CW = 3;

    logic          clk;
    logic          reset_n;
    logic          hold;
    logic          drain;
    logic          drained;
    logic [CW-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    bp_fe_bp_update_sched_if #(.bht_idx_width_p(IW)) upd ();

    bp_fe_bp_update_sched #(
        .bht_idx_width_p (IW),
        .fifo_els_p      (4)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .upd       (upd.slave),
        .hold_i    (hold),
        .drain_i   (drain),
        .drained_o (drained),
        .count_o   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in;
        upd.cmt_v_i       = 1'b0;
        upd.cmt_idx_i     = '0;
        upd.cmt_correct_i = 1'b0;
        upd.rdr_v_i       = 1'b0;
        upd.rdr_idx_i     = '0;
        upd.rdr_correct_i = 1'b0;
    endtask

    // contention table: commit 1,2 vs redirect 5,6
    int tcv[5]  = '{1, 1, 1, 0, 0};
    int tci[5]  = '{1, 2, 2, 0, 0};
    int trv[5]  = '{1, 1, 1, 1, 0};
    int tri_[5] = '{5, 5, 6, 6, 0};
    int ecr[5]  = '{1, 0, 1, 0, 1};
    int err_[5] = '{0, 1, 0, 1, 1};
    int ewv[5]  = '{0, 1, 1, 1, 1};
    int ewi[5]  = '{0, 1, 5, 2, 6};
    int ewc[5]  = '{0, 0, 1, 0, 1};

    initial begin
        reset_n = 1'b0;
        hold    = 1'b0;
        drain   = 1'b0;
        idle_in();
        @(negedge clk);
        tick();
        #1;
        chk("rst_cmt_rdy", 32'(upd.cmt_ready_o), 0);
        chk("rst_rdr_rdy", 32'(upd.rdr_ready_o), 0);
        chk("rst_wv", 32'(upd.w_v_o), 0);
        chk("rst_idx", 32'(upd.idx_w_o), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drained", 32'(drained), 0);
        reset_n = 1'b1;
        tick();

        // single commit update
        upd.cmt_v_i       = 1'b1;
        upd.cmt_idx_i     = 4'd3;
        upd.cmt_correct_i = 1'b1;
        #1;
        chk("one_rdy", 32'(upd.cmt_ready_o), 1);
        chk("one_nobypass", 32'(upd.w_v_o), 0);
        tick();
        idle_in();
        #1;
        chk("one_wv", 32'(upd.w_v_o), 1);
        chk("one_idx", 32'(upd.idx_w_o), 3);
        chk("one_cor", 32'(upd.correct_o), 1);
        chk("one_cnt1", 32'(count), 1);
        tick();
        #1;
        chk("one_cnt0", 32'(count), 0);
        chk("one_wv0", 32'(upd.w_v_o), 0);
        chk("one_idx0", 32'(upd.idx_w_o), 0);

        // contention: round-robin C,R,C,R
        for (int i = 0; i < 5; i++) begin
            upd.cmt_v_i       = tcv[i][0];
            upd.cmt_idx_i     = IW'(tci[i]);
            upd.cmt_correct_i = 1'b0;
            upd.rdr_v_i       = trv[i][0];
            upd.rdr_idx_i     = IW'(tri_[i]);
            upd.rdr_correct_i = 1'b1;
            #1;
            chk($sformatf("ct%0d_crdy", i), 32'(upd.cmt_ready_o), 32'(ecr[i]));
            chk($sformatf("ct%0d_rrdy", i), 32'(upd.rdr_ready_o), 32'(err_[i]));
            chk($sformatf("ct%0d_wv", i), 32'(upd.w_v_o), 32'(ewv[i]));
            chk($sformatf("ct%0d_idx", i), 32'(upd.idx_w_o), 32'(ewi[i]));
            chk($sformatf("ct%0d_cor", i), 32'(upd.correct_o), 32'(ewc[i]));
            tick();
        end
        idle_in();
        #1;
        chk("ct_empty", 32'(count), 0);

        // fill to full under hold, fifth blocked
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            upd.cmt_v_i   = 1'b1;
            upd.cmt_idx_i = IW'(9 + i);
            #1;
            chk($sformatf("full%0d_rdy", i), 32'(upd.cmt_ready_o), (i < 4) ? 1 : 0);
            chk($sformatf("full%0d_cnt", i), 32'(count), 32'(i));
            chk($sformatf("full%0d_wv", i), 32'(upd.w_v_o), 0);
            if (i < 4)
                tick();
        end
        idle_in();
        hold = 1'b0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk($sformatf("fdq%0d_wv", j), 32'(upd.w_v_o), 1);
            chk($sformatf("fdq%0d_idx", j), 32'(upd.idx_w_o), 32'(9 + j));
            tick();
        end
        #1;
        chk("fdq_wv0", 32'(upd.w_v_o), 0);
        chk("fdq_cnt0", 32'(count), 0);

        // drain on empty queue
        drain = 1'b1;
        #1;
        chk("de0_drained", 32'(drained), 0);
        tick();
        drain = 1'b0;
        #1;
        chk("de1_drained", 32'(drained), 0);
        chk("de1_rdy", 32'(upd.cmt_ready_o), 0);
        tick();
        #1;
        chk("de2_drained", 32'(drained), 1);
        chk("de2_rdy", 32'(upd.rdr_ready_o), 0);
        tick();
        #1;
        chk("de3_drained", 32'(drained), 0);
        chk("de3_rdy", 32'(upd.cmt_ready_o), 1);

        // drain with 3 queued entries
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            upd.rdr_v_i   = 1'b1;
            upd.rdr_idx_i = IW'(2 + i);
            tick();
        end
        idle_in();
        hold  = 1'b0;
        drain = 1'b1;
        #1;
        chk("dr0_cnt", 32'(count), 3);
        chk("dr0_wv", 32'(upd.w_v_o), 1);
        chk("dr0_idx", 32'(upd.idx_w_o), 2);
        tick();
        drain = 1'b0;
        for (int k = 1; k < 6; k++) begin
            #1;
            chk($sformatf("dr%0d_wv", k), 32'(upd.w_v_o), (k < 3) ? 1 : 0);
            chk($sformatf("dr%0d_idx", k), 32'(upd.idx_w_o), (k < 3) ? 32'(2 + k) : 0);
            chk($sformatf("dr%0d_cnt", k), 32'(count), (k < 3) ? 32'(3 - k) : 0);
            chk($sformatf("dr%0d_drained", k), 32'(drained), (k == 4) ? 1 : 0);
            chk($sformatf("dr%0d_crdy", k), 32'(upd.cmt_ready_o), (k == 5) ? 1 : 0);
            chk($sformatf("dr%0d_rrdy", k), 32'(upd.rdr_ready_o), (k == 5) ? 1 : 0);
            tick();
        end

        // reset in the middle of a held drain
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            upd.cmt_v_i   = 1'b1;
            upd.cmt_idx_i = IW'(7 + i);
            tick();
        end
        idle_in();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        tick();
        #1;
        chk("mr_cnt2", 32'(count), 2);
        chk("mr_rdy_drain", 32'(upd.cmt_ready_o), 0);
        reset_n = 1'b0;
        hold    = 1'b0;
        #1;
        chk("mr_in_rst_wv", 32'(upd.w_v_o), 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mr_cnt0", 32'(count), 0);
        chk("mr_wv0", 32'(upd.w_v_o), 0);
        chk("mr_rdy_run", 32'(upd.cmt_ready_o), 1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("mr%0d_drained", k), 32'(drained), 0);
            chk($sformatf("mr%0d_wv", k), 32'(upd.w_v_o), 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
